// File: rtl/uart_prog_loader.sv
// UART program loader: receives an 8N1 byte stream, decodes a 14-bit word
// count header, assembles little-endian 32-bit words and writes them to
// program memory, then releases the memory via upg_done_o.
module uart_prog_loader #(
    parameter int CLK_HZ = 10000000,
    parameter int BAUD   = 115200
) (
    input  logic        upg_clk_i,
    input  logic        rst,
    input  logic        rx_i,
    output logic        upg_wen_o,
    output logic [13:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_HDR0, LD_HDR1, LD_DATA, LD_DONE} ld_state_t;

    rx_state_t rx_state, rx_next;
    ld_state_t ld_state, ld_next;

    logic          rx_s1, rx_s2, rx_d;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          byte_valid;

    logic [7:0]    cnt_lo;
    logic [13:0]   count;
    logic [13:0]   count_next;
    logic [1:0]    lane;
    logic [23:0]   wbuf;
    logic [13:0]   idx;
    logic          last_q;

    assign count_next = {shreg[5:0], cnt_lo};

    // Two-flop synchronizer plus one delay stage for falling-edge detection
    always_ff @(posedge upg_clk_i or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // Receiver state register
    always_ff @(posedge upg_clk_i or posedge rst) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    // Receiver next-state: sample at mid-bit, reject false starts
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_d && !rx_s2) rx_next = RX_START;
            RX_START: if (cnt == '0) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt == '0 && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (cnt == '0) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Receiver datapath: bit timer, shift register, byte strobe, frame error
    always_ff @(posedge upg_clk_i or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            byte_valid  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    cnt     <= HALF_M1;
                    bit_idx <= '0;
                end
                RX_START: cnt <= (cnt == '0) ? FULL_M1 : cnt - 1'b1;
                RX_DATA: begin
                    if (cnt == '0) begin
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        cnt     <= FULL_M1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == '0) begin
                        if (rx_s2) byte_valid  <= 1'b1;
                        else       frame_err_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Loader state register
    always_ff @(posedge upg_clk_i or posedge rst) begin
        if (rst) ld_state <= LD_HDR0;
        else     ld_state <= ld_next;
    end

    // Loader next-state: header, data words, then done once the last write issues
    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            LD_HDR0: if (byte_valid) ld_next = LD_HDR1;
            LD_HDR1: if (byte_valid) ld_next = (count_next == '0) ? LD_DONE : LD_DATA;
            LD_DATA: if (upg_wen_o && last_q) ld_next = LD_DONE;
            LD_DONE: ld_next = LD_DONE;
            default: ld_next = LD_HDR0;
        endcase
    end

    // Loader datapath: header capture, word assembly, write strobe, status
    always_ff @(posedge upg_clk_i or posedge rst) begin
        if (rst) begin
            cnt_lo     <= '0;
            count      <= '0;
            lane       <= '0;
            wbuf       <= '0;
            idx        <= '0;
            last_q     <= 1'b0;
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= '0;
            upg_done_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            upg_wen_o  <= 1'b0;
            upg_done_o <= (ld_next == LD_DONE);
            busy_o     <= (ld_next == LD_HDR1) || (ld_next == LD_DATA);
            case (ld_state)
                LD_HDR0: if (byte_valid) cnt_lo <= shreg;
                LD_HDR1: if (byte_valid) count <= count_next;
                LD_DATA: begin
                    if (byte_valid) begin
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: wbuf[7:0]   <= shreg;
                            2'd1: wbuf[15:8]  <= shreg;
                            2'd2: wbuf[23:16] <= shreg;
                            default: begin
                                upg_wen_o <= 1'b1;
                                upg_adr_o <= idx;
                                upg_dat_o <= {shreg, wbuf};
                                idx       <= idx + 14'd1;
                                last_q    <= (idx == count - 14'd1);
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: table-driven images, hand-written reset
// sequence and randomized images checked against a byte-level model.
module tb_uart_prog_loader;

    localparam int CLK_HZ = 10000000;
    localparam int BAUD   = 1000000;
    localparam int DIV    = CLK_HZ / BAUD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        wen;
    logic [13:0] adr;
    logic [31:0] dat;
    logic        done;
    logic        ferr;
    logic        busy;

    always #5 clk = ~clk;

    uart_prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .upg_clk_i  (clk),
        .rst        (rst),
        .rx_i       (rx),
        .upg_wen_o  (wen),
        .upg_adr_o  (adr),
        .upg_dat_o  (dat),
        .upg_done_o (done),
        .frame_err_o(ferr),
        .busy_o     (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
        end
    endtask

    // Write capture and per-cycle protocol checks
    logic [13:0] got_adr[$];
    logic [31:0] got_dat[$];
    int          cyc = 0;
    int          last_wen_cyc = -10;
    logic        prev_wen = 1'b0;
    logic        prev_done = 1'b0;
    logic        have_w = 1'b0;
    logic [13:0] h_adr = '0;
    logic [31:0] h_dat = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("wen_in_reset", 64'(wen), 64'(0));
            have_w = 1'b0;
        end else begin
            if (wen) begin
                chk("wen_width", 64'(prev_wen), 64'(0));
                got_adr.push_back(adr);
                got_dat.push_back(dat);
                last_wen_cyc = cyc;
                have_w = 1'b1;
                h_adr = adr;
                h_dat = dat;
            end else if (have_w) begin
                chk("adr_hold", 64'(adr), 64'(h_adr));
                chk("dat_hold", 64'(dat), 64'(h_dat));
            end
            if (done && !prev_done && got_adr.size() > 0)
                chk("done_after_wen", 64'(cyc - last_wen_cyc), 64'(1));
        end
        prev_wen  = wen;
        prev_done = done;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stopb);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(DIV);
        end
        rx = stopb;
        tick(DIV);
        rx = 1'b1;
        tick(DIV);
    endtask

    task automatic do_reset();
        rx  = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    // Stimulus and model state
    logic [7:0]  in_b[$];
    logic        in_bad[$];
    logic [13:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    logic        exp_done;
    logic        exp_busy;
    logic        exp_ferr;

    // Reference: walk good bytes through header / words / done rules
    task automatic model();
        int st = 0;
        int cnt = 0;
        int idx = 0;
        int lane = 0;
        logic [31:0] w = '0;
        exp_adr.delete();
        exp_dat.delete();
        exp_ferr = 1'b0;
        foreach (in_b[i]) begin
            if (in_bad[i]) begin
                exp_ferr = 1'b1;
            end else begin
                case (st)
                    0: begin cnt = int'(in_b[i]); st = 1; end
                    1: begin
                        cnt = cnt + (int'(in_b[i]) % 64) * 256;
                        st = (cnt == 0) ? 3 : 2;
                    end
                    2: begin
                        w[8*lane +: 8] = in_b[i];
                        lane++;
                        if (lane == 4) begin
                            exp_adr.push_back(14'(idx % 16384));
                            exp_dat.push_back(w);
                            idx++;
                            lane = 0;
                            if (idx == cnt) st = 3;
                        end
                    end
                    default: ;
                endcase
            end
        end
        exp_done = (st == 3);
        exp_busy = (st == 1) || (st == 2);
    endtask

    task automatic check_results(input string nm, input int exp_n);
        int n;
        model();
        if (exp_n >= 0) chk($sformatf("%s_nwr_table", nm), 64'(got_adr.size()), 64'(exp_n));
        chk($sformatf("%s_nwr", nm), 64'(got_adr.size()), 64'(exp_adr.size()));
        n = (got_adr.size() < exp_adr.size()) ? got_adr.size() : exp_adr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_adr%0d", nm, i), 64'(got_adr[i]), 64'(exp_adr[i]));
            chk($sformatf("%s_dat%0d", nm, i), 64'(got_dat[i]), 64'(exp_dat[i]));
        end
        chk($sformatf("%s_done", nm), 64'(done), 64'(exp_done));
        chk($sformatf("%s_busy", nm), 64'(busy), 64'(exp_busy));
        chk($sformatf("%s_ferr", nm), 64'(ferr), 64'(exp_ferr));
    endtask

    task automatic run_image(input string nm, input bit glitch, input int exp_n);
        do_reset();
        got_adr.delete();
        got_dat.delete();
        chk($sformatf("%s_reset", nm), 64'({wen, adr, dat, done, ferr, busy}), 64'(0));
        if (glitch) begin
            rx = 1'b0;
            tick(3);
            rx = 1'b1;
            tick(3 * DIV);
            chk($sformatf("%s_glitch_busy", nm), 64'(busy), 64'(0));
            chk($sformatf("%s_glitch_ferr", nm), 64'(ferr), 64'(0));
        end
        foreach (in_b[i]) send_byte(in_b[i], !in_bad[i]);
        tick(3 * DIV);
        check_results(nm, exp_n);
    endtask

    typedef struct {
        int               n;
        logic [0:15][7:0] b;
        logic [0:15]      bad;
        bit               glitch;
        int               exp_wr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{10, {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE,
                         8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    16'b0, 1'b0, 2};
        vecs[1] = '{2,  {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                         8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    16'b0, 1'b0, 0};
        vecs[2] = '{6,  {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00,
                         8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    16'b0, 1'b1, 1};
        vecs[3] = '{7,  {8'h01, 8'h00, 8'h11, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00,
                         8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    16'b0010_0000_0000_0000, 1'b0, 1};
        vecs[4] = '{10, {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                         8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    16'b0, 1'b0, 1};
        vecs[5] = '{6,  {8'h01, 8'hC0, 8'h0D, 8'hF0, 8'hAD, 8'h0B, 8'h00, 8'h00,
                         8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    16'b0, 1'b0, 1};

        tick(2);
        chk("por_wen", 64'(wen), 64'(0));
        chk("por_done", 64'(done), 64'(0));

        // Table-driven images
        for (int v = 0; v < 6; v++) begin
            in_b.delete();
            in_bad.delete();
            for (int i = 0; i < vecs[v].n; i++) begin
                in_b.push_back(vecs[v].b[i]);
                in_bad.push_back(vecs[v].bad[i]);
            end
            run_image($sformatf("vec%0d", v), vecs[v].glitch, vecs[v].exp_wr);
        end

        // Reset mid-image and mid-byte, then a clean reload
        do_reset();
        got_adr.delete();
        got_dat.delete();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        fork
            send_byte(8'h33, 1'b1);
            begin
                tick(4 * DIV);
                rst = 1'b1;
            end
        join
        for (int i = 0; i < 40; i++) begin
            rx = 1'($urandom_range(0, 1));
            tick(1);
        end
        rx = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("rstmid_busy", 64'(busy), 64'(0));
        chk("rstmid_done", 64'(done), 64'(0));
        in_b = '{8'h01, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        in_bad = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        foreach (in_b[i]) send_byte(in_b[i], 1'b1);
        tick(3 * DIV);
        check_results("rstmid", 1);
        if (got_dat.size() > 0) chk("rstmid_word", 64'(got_dat[0]), 64'(32'hD4C3B2A1));

        // Randomized images with junk header bits and occasional bad frames
        for (int r = 0; r < 4; r++) begin
            int wc;
            wc = $urandom_range(1, 3);
            in_b.delete();
            in_bad.delete();
            in_b.push_back(8'(wc));
            in_bad.push_back(1'b0);
            in_b.push_back(8'($urandom_range(0, 3) << 6));
            in_bad.push_back(1'b0);
            for (int i = 0; i < 4 * wc + 2; i++) begin
                in_b.push_back(8'($urandom_range(0, 255)));
                in_bad.push_back($urandom_range(0, 9) == 0);
            end
            run_image($sformatf("rnd%0d", r), 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter CLK_HZ, default 10000000, upg_clk_i frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; DIV = CLK_HZ/BAUD (integer division, 86 at defaults).
REQ-003 upg_clk_i  input  1  loader clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_i  input  1  UART serial input, idle high, 8N1, LSB first.
REQ-006 upg_wen_o  output  1  one-cycle memory write strobe.
REQ-007 upg_adr_o  output  14  memory word address for the current write.
REQ-008 upg_dat_o  output  32  memory write data.
REQ-009 upg_done_o  output  1  image load complete; memory released to the CPU.
REQ-010 frame_err_o  output  1  sticky flag; a byte with a bad stop bit was received.
REQ-011 busy_o  output  1  high from header byte 0 acceptance until upg_done_o rises.

Function -- receiver
REQ-012 rx_i shall pass through a 2-flop synchronizer before any use.
REQ-013 RX FSM states: IDLE, START, DATA, STOP.
REQ-014 IDLE->START on a synchronized high-to-low transition; the bit counter loads DIV/2.
REQ-015 START: at DIV/2 cycles, a sampled 1 is a false start (->IDLE, no byte); a sampled 0 ->DATA.
REQ-016 DATA: 8 samples, DIV cycles apart, shifted in LSB first; ->STOP after bit 7.
REQ-017 STOP: sample after DIV cycles; 1 produces a one-cycle byte_valid with the byte; 0 sets frame_err_o, discards the byte; both ->IDLE.
REQ-018 The receiver shall keep running in every loader state, including DONE.

Function -- loader
REQ-019 Loader FSM states: HDR0, HDR1, DATA, DONE; reset state HDR0.
REQ-020 HDR0: the byte becomes count[7:0]; ->HDR1.
REQ-021 HDR1: the byte supplies count[13:8] (bits 7:6 ignored); count==0 ->DONE, else ->DATA.
REQ-022 DATA: bytes assemble little-endian (byte0 -> dat[7:0] ... byte3 -> dat[31:24]).
REQ-023 On the 4th byte, the next cycle shall drive upg_wen_o=1 for exactly one cycle, with upg_dat_o = the assembled word and upg_adr_o = the word index.
REQ-024 The word index starts at 0 and increments by 1 after each write; it wraps from 16383 to 0.
REQ-025 upg_adr_o and upg_dat_o shall hold their last values while upg_wen_o=0.
REQ-026 After the write of word count-1, the FSM moves ->DONE; upg_done_o rises the cycle after that wen pulse; busy_o falls in the same cycle.
REQ-027 DONE: upg_done_o stays 1; all bytes are ignored; no further wen until reset.
REQ-028 A framed-bad byte does not advance the byte lane or FSM.

Reset
REQ-029 rst=1 shall immediately force: RX IDLE, loader HDR0, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, frame_err_o=0, busy_o=0, word index 0, byte lane 0.
REQ-030 A reset mid-byte or mid-image shall abandon the partial data; after rst falls, the next start bit is treated as header byte 0.
REQ-031 While rst=1, upg_wen_o shall remain 0 regardless of rx_i.

Verification
REQ-032 Send 0x02,0x00,0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE -> wen at adr 0 dat 0x12345678, then adr 1 dat 0xDEADBEEF; upg_done_o=1 one cycle after the 2nd wen.
REQ-033 Send 0x00,0x00 -> no wen; upg_done_o=1 after the 2nd byte; busy_o returns to 0.
REQ-034 A 0.3-bit low glitch on idle rx_i -> no byte accepted, loader stays in HDR0, frame_err_o=0.
REQ-035 After header 0x01,0x00, send 0x11 with stop bit 0, then 0xAA,0xBB,0xCC,0xDD -> frame_err_o=1; single wen with adr 0, dat 0xDDCCBBAA.
REQ-036 Assert rst after 2 data bytes of a 1-word image, release it, resend the full image -> exactly one wen with adr 0 and the correct data.
REQ-037 After DONE, send 4 further bytes -> no wen; upg_done_o stays 1.
